// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared key indices, default key count and counter width helper for key_cond
package key_cond_pkg;

  // button channel indices as wired on the board
  localparam int KEY_CAT       = 0;
  localparam int KEY_DOG       = 1;
  localparam int KEY_MOUSE     = 2;
  localparam int KEY_HUMAN     = 3;

  localparam int NKEYS_DEFAULT = 4;

  // one counter width serves both the debounce and the repeat timer
  function automatic int cnt_w_f(input int db_ms, input int repeat_ms);
    int m;
    m = (db_ms > repeat_ms) ? db_ms : repeat_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_1.sv
// rtl/key_debounce_1.sv - one key: synchronizer, debounce counter, level and rise detect, optional KEY_AUTOREPEAT_EN repeat timer
module key_debounce_1
  import key_cond_pkg::*;
#(
  parameter int DB_MS     = 20,
  parameter int REPEAT_MS = 500
) (
  input  logic clk1khz,
  input  logic rst,
  input  logic off,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W   = cnt_w_f(DB_MS, REPEAT_MS);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_MS - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             qualify;
  logic             first_rise;

  // qualify fires on the DB_MS-th consecutive edge where the synced input disagrees with level
  assign mismatch   = (s2 != level);
  assign qualify    = mismatch && (cnt == DB_LAST);
  assign first_rise = qualify && !level;

  // two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk1khz) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // debounce: any agreeing sample restarts the count, a full run toggles the level
  always_ff @(posedge clk1khz) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!mismatch) begin
      cnt   <= '0;
    end else if (qualify) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_arm;
  logic             rep_fire;

  // only armed by a rise seen outside off, so a key held across off never repeats
  assign rep_fire = rep_arm && level && !qualify && (rep_cnt == REP_LAST);

  // repeat timer: restarts at each first rise, cleared by release, rst and off
  always_ff @(posedge clk1khz) begin
    if (rst || off) begin
      rep_cnt <= '0;
      rep_arm <= 1'b0;
    end else if (first_rise) begin
      rep_cnt <= '0;
      rep_arm <= 1'b1;
    end else if (!level || qualify) begin
      rep_cnt <= '0;
      rep_arm <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt <= '0;
    end else if (rep_arm) begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end

  assign rise = (first_rise || rep_fire) && !off;
`else
  assign rise = first_rise && !off;
`endif

endmodule

// File: rtl/key_cond.sv
// rtl/key_cond.sv - button conditioning top: per-key debounce, press pulses, latched requests and drop flags (option KEY_AUTOREPEAT_EN)
module key_cond
  import key_cond_pkg::*;
#(
  parameter int NKEYS     = NKEYS_DEFAULT,
  parameter int DB_MS     = 20,
  parameter int REPEAT_MS = 500
) (
  input  logic             clk1khz,
  input  logic             rst,
  input  logic             off,
  input  logic [NKEYS-1:0] key_raw,
  input  logic [NKEYS-1:0] key_ack,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_pulse,
  output logic [NKEYS-1:0] key_req,
  output logic [NKEYS-1:0] key_drop
);

  logic [NKEYS-1:0] key_rise;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_1 #(
      .DB_MS     (DB_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_db (
      .clk1khz (clk1khz),
      .rst     (rst),
      .off     (off),
      .key_raw (key_raw[i]),
      .level   (key_level[i]),
      .rise    (key_rise[i])
    );
  end

  // request latch: a new press beats a same-edge ack; a press onto an unacked request is a drop
  always_ff @(posedge clk1khz) begin
    if (rst || off) begin
      key_pulse <= '0;
      key_req   <= '0;
      key_drop  <= '0;
    end else begin
      key_pulse <= key_rise;
      key_req   <= key_rise | (key_req & ~key_ack);
      key_drop  <= key_drop | (key_rise & key_req & ~key_ack);
    end
  end

endmodule

// File: tb/tb_key_cond.sv
// tb/tb_key_cond.sv - scoreboard bench for key_cond with directed press, bounce, collision, off, reset and hold vectors
module tb_key_cond;
  import key_cond_pkg::*;

  logic       clk1khz = 1'b0;
  logic       rst     = 1'b1;
  logic       off     = 1'b0;
  logic [3:0] key_raw = '0;
  logic [3:0] key_ack = '0;
  logic [3:0] key_level;
  logic [3:0] key_pulse;
  logic [3:0] key_req;
  logic [3:0] key_drop;

  key_cond #(
    .NKEYS     (4),
    .DB_MS     (20),
    .REPEAT_MS (50)
  ) dut (
    .clk1khz   (clk1khz),
    .rst       (rst),
    .off       (off),
    .key_raw   (key_raw),
    .key_ack   (key_ack),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .key_req   (key_req),
    .key_drop  (key_drop)
  );

  always #5 clk1khz = ~clk1khz;

  int edge_n = 0;
  always @(posedge clk1khz) edge_n = edge_n + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_req  = '0;
  logic [3:0] prev_drop = '0;

  function automatic void push(int cyc, string name, logic [3:0] p, logic [3:0] r,
                               logic [3:0] d, logic [3:0] l);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.v    = {p, r, d, l};
    sb.push_back(e);
  endfunction

  task automatic tick(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk1khz);
      #1;
    end
  endtask

  task automatic tick_to(int target);
    while (edge_n < target) tick(1);
  endtask

  task automatic chk(string name, logic [3:0] got, logic [3:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got=%b want=%b at edge %0d", name, got, want, edge_n);
    end
  endtask

  // monitor: any pulse or req/drop change is an output event and must match the head of the scoreboard
  always @(negedge clk1khz) begin
    if (mon_en) begin
      if (key_pulse != 4'b0 || key_req != prev_req || key_drop != prev_drop) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_event edge=%0d pulse=%b req=%b drop=%b level=%b",
                   edge_n, key_pulse, key_req, key_drop, key_level);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc != edge_n || e.v !== {key_pulse, key_req, key_drop, key_level}) begin
            errors = errors + 1;
            $display("FAIL %s got edge=%0d p/r/d/l=%b_%b_%b_%b want edge=%0d p/r/d/l=%b_%b_%b_%b",
                     e.name, edge_n, key_pulse, key_req, key_drop, key_level,
                     e.cyc, e.v[15:12], e.v[11:8], e.v[7:4], e.v[3:0]);
          end
        end
      end
      prev_req  = key_req;
      prev_drop = key_drop;
    end
  end

  int c;
  int last;
  int q;

  initial begin
    // reset
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_level", key_level, 4'b0000);
    chk("reset_pulse", key_pulse, 4'b0000);
    chk("reset_req",   key_req,   4'b0000);
    chk("reset_drop",  key_drop,  4'b0000);
    mon_en = 1'b1;

    // clean press on the human key, then ack
    c = edge_n;
    key_raw[KEY_HUMAN] = 1'b1;
    push(c + 22, "clean_press", 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    push(c + 31, "clean_ack",   4'b0000, 4'b0000, 4'b0000, 4'b1000);
    tick_to(c + 30);
    key_ack[KEY_HUMAN] = 1'b1;
    tick(1);
    key_ack[KEY_HUMAN] = 1'b0;
    tick_to(c + 35);
    key_raw[KEY_HUMAN] = 1'b0;
    tick_to(c + 60);

    // bounce on the cat key: toggle every 5 cycles for 60 cycles, then hold
    c = edge_n;
    last = c;
    for (int i = 0; i <= 12; i++) begin
      key_raw[KEY_CAT] = (i % 2 == 0);
      last = edge_n;
      if (i < 12) tick(5);
    end
    push(last + 22, "bounce_press", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    push(last + 31, "bounce_ack",   4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tick_to(last + 30);
    key_ack[KEY_CAT] = 1'b1;
    tick(1);
    key_ack[KEY_CAT] = 1'b0;
    tick_to(last + 35);
    key_raw[KEY_CAT] = 1'b0;
    tick_to(last + 60);

    // dog key: press, press colliding with ack, press without ack
    c = edge_n;
    key_raw[KEY_DOG] = 1'b1;
    push(c + 22,  "dog_press",   4'b0010, 4'b0010, 4'b0000, 4'b0010);
    push(c + 72,  "ack_collide", 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    push(c + 122, "press_drop",  4'b0010, 4'b0010, 4'b0010, 4'b0010);
    tick_to(c + 25);
    key_raw[KEY_DOG] = 1'b0;
    tick_to(c + 50);
    key_raw[KEY_DOG] = 1'b1;
    tick_to(c + 71);
    key_ack[KEY_DOG] = 1'b1;
    tick(1);
    key_ack[KEY_DOG] = 1'b0;
    tick_to(c + 75);
    key_raw[KEY_DOG] = 1'b0;
    tick_to(c + 100);
    key_raw[KEY_DOG] = 1'b1;
    tick_to(c + 125);
    key_raw[KEY_DOG] = 1'b0;
    tick_to(c + 150);

    // mouse key qualifies during off; held across off release; release and re-press
    c = edge_n;
    key_raw[KEY_MOUSE] = 1'b1;
    push(c + 6,   "off_clear",   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(c + 109, "off_repress", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    push(c + 116, "mouse_ack",   4'b0000, 4'b0000, 4'b0000, 4'b0100);
    tick_to(c + 5);
    off = 1'b1;
    tick_to(c + 35);
    off = 1'b0;
    tick_to(c + 40);
    chk("off_held_req",   key_req,   4'b0000);
    chk("off_held_level", key_level, 4'b0100);
    tick_to(c + 65);
    key_raw[KEY_MOUSE] = 1'b0;
    tick_to(c + 87);
    key_raw[KEY_MOUSE] = 1'b1;
    tick_to(c + 115);
    key_ack[KEY_MOUSE] = 1'b1;
    tick(1);
    key_ack[KEY_MOUSE] = 1'b0;
    key_raw[KEY_MOUSE] = 1'b0;
    tick_to(c + 140);

    // reset while the human key is held with a pending request
    c = edge_n;
    key_raw[KEY_HUMAN] = 1'b1;
    push(c + 22, "rst_pre_press", 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    push(c + 31, "rst_mid_press", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(c + 53, "rst_repress",   4'b1000, 4'b1000, 4'b0000, 4'b1000);
    push(c + 61, "rst_ack",       4'b0000, 4'b0000, 4'b0000, 4'b1000);
    tick_to(c + 30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick_to(c + 60);
    key_ack[KEY_HUMAN] = 1'b1;
    tick(1);
    key_ack[KEY_HUMAN] = 1'b0;
    key_raw[KEY_HUMAN] = 1'b0;
    tick_to(c + 90);

    // long hold on the cat key with periodic acks
    c = edge_n;
    q = c + 22;
    key_raw[KEY_CAT] = 1'b1;
    push(q,     "hold_first", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    push(q + 9, "hold_ack0",  4'b0000, 4'b0000, 4'b0000, 4'b0001);
`ifdef KEY_AUTOREPEAT_EN
    push(q + 50,  "repeat_50",  4'b0001, 4'b0001, 4'b0000, 4'b0001);
    push(q + 59,  "hold_ack1",  4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(q + 100, "repeat_100", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    push(q + 109, "hold_ack2",  4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(q + 150, "repeat_150", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    push(q + 159, "hold_ack3",  4'b0000, 4'b0000, 4'b0000, 4'b0001);
`endif
    for (int k = 0; k < 4; k++) begin
      tick_to(q + 8 + 50 * k);
      key_ack[KEY_CAT] = 1'b1;
      tick(1);
      key_ack[KEY_CAT] = 1'b0;
    end
    tick_to(q + 175);
    key_raw[KEY_CAT] = 1'b0;
    tick_to(q + 260);

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drained got=%0d pending want=0, next=%s", sb.size(), sb[0].name);
    end
    chk("final_level", key_level, 4'b0000);
    chk("final_req",   key_req,   4'b0000);
    chk("final_drop",  key_drop,  4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
